axi_sram_slave: RTL and testbench

- AXI3 slave (responder) that turns AXI read/write transactions into accesses on a single-port synchronous SRAM with 1-cycle read latency.
- It is the far end of the CPU's AXI master: it sits between the core's AXI ports and on-chip RAM, used in SoC integration and in CPU-level simulation.
- It handles one transaction at a time and supports INCR bursts of up to 16 beats.

---
 rtl/axi_sram_slave.sv | 171 +++++++++++++++++
 tb/tb_axi_sram_slave.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI3 slave bridging single-outstanding read/write INCR/FIXED bursts (<=16 beats)
// onto a single-port synchronous SRAM with 1-cycle read latency.
module axi_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [3:0]            arid,
  input  logic [31:0]           araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [3:0]            rid,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [3:0]            awid,
  input  logic [31:0]           awaddr,
  input  logic [3:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [3:0]            bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  sram_en,
  output logic [3:0]            sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] RD_RESP = 3'd3;
  localparam logic [2:0] WR_DATA = 3'd4;
  localparam logic [2:0] WR_RESP = 3'd5;

  logic [2:0]  state_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [3:0]  beat_q;
  logic [3:0]  rid_q;
  logic [3:0]  bid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        last_wr_q;

  logic        grant_rd;
  logic        ar_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        beat_last;
  logic [31:0] next_addr;
  logic        unused_ok;

  assign unused_ok = ^arlen[7:4];

  // Ties go to whichever side did not win the previous tie; uncontested grants leave the bit alone.
  assign grant_rd  = arvalid && (!awvalid || last_wr_q);
  assign ar_hs     = aresetn && (state_q == IDLE) && grant_rd;
  assign aw_hs     = aresetn && (state_q == IDLE) && awvalid && !grant_rd;
  assign w_hs      = (state_q == WR_DATA) && wvalid;
  assign beat_last = (beat_q == len_q);
  assign next_addr = (burst_q == 2'b01) ? addr_q + (32'd1 << size_q) : addr_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      rid_q     <= '0;
      bid_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      last_wr_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs) begin
            rid_q   <= arid;
            addr_q  <= araddr;
            len_q   <= arlen[3:0];
            size_q  <= arsize;
            burst_q <= arburst;
            beat_q  <= '0;
            if (awvalid) last_wr_q <= 1'b0;
            state_q <= RD_REQ;
          end else if (aw_hs) begin
            bid_q   <= awid;
            addr_q  <= awaddr;
            len_q   <= awlen;
            size_q  <= awsize;
            burst_q <= awburst;
            beat_q  <= '0;
            if (arvalid) last_wr_q <= 1'b1;
            state_q <= WR_DATA;
          end
        end
        RD_REQ:  state_q <= RD_WAIT;
        RD_WAIT: begin
          rdata_q <= sram_rdata;
          state_q <= RD_RESP;
        end
        RD_RESP: begin
          if (rready) begin
            if (beat_last) begin
              state_q <= IDLE;
            end else begin
              beat_q  <= beat_q + 4'd1;
              addr_q  <= next_addr;
              state_q <= RD_REQ;
            end
          end
        end
        WR_DATA: begin
          if (wvalid) begin
            if (wlast != beat_last) err_q <= 1'b1;
            if (beat_last) begin
              state_q <= WR_RESP;
            end else begin
              beat_q <= beat_q + 4'd1;
              addr_q <= next_addr;
            end
          end
        end
        WR_RESP: begin
          if (bready) begin
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arready    = ar_hs;
  assign awready    = aw_hs;
  assign rvalid     = (state_q == RD_RESP);
  assign rlast      = rvalid && beat_last;
  assign rid        = rid_q;
  assign rdata      = rdata_q;
  assign rresp      = '0;
  assign wready     = (state_q == WR_DATA);
  assign bvalid     = (state_q == WR_RESP);
  assign bid        = bid_q;
  assign bresp      = (bvalid && err_q) ? 2'b10 : 2'b00;
  assign sram_en    = (state_q == RD_REQ) || w_hs;
  assign sram_wen   = w_hs ? wstrb : '0;
  assign sram_wdata = w_hs ? wdata : '0;
  assign sram_addr  = addr_q[ADDR_WIDTH+1:2];

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave with a behavioural SRAM model.
module tb_axi_sram_slave;
  localparam int unsigned AW = 16;

  logic          aclk, aresetn;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid, arready;
  logic [3:0]    rid;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [3:0]    awid;
  logic [31:0]   awaddr;
  logic [3:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid, awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wlast, wvalid, wready;
  logic [3:0]    bid;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic          sram_en;
  logic [3:0]    sram_wen;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  int checks = 0;
  int errors = 0;

  axi_sram_slave #(.ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // SRAM model: unwritten words come from init_word, written words from mem.
  logic [31:0] mem [int unsigned];

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    case (a)
      16'h0040: return 32'hDEADBEEF;
      16'h0041: return 32'h12345678;
      16'h0042: return 32'h11111111;
      16'h0004: return 32'h0BADF00D;
      default:  return {16'hA000, a};
    endcase
  endfunction

  always @(posedge aclk) begin : sram_model
    logic [31:0] cur;
    if (sram_en) begin
      cur = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : init_word(sram_addr);
      if (sram_wen != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) cur[8*b +: 8] = sram_wdata[8*b +: 8];
        mem[int'(sram_addr)] = cur;
      end else begin
        sram_rdata <= cur;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_ar(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
  endtask

  task automatic finish_ar();
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (arready) begin seen = 1; break; end
    end
    chk("ar_handshake", 32'(seen), 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic start_aw(input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst);
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
  endtask

  task automatic finish_aw();
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (awready) begin seen = 1; break; end
    end
    chk("aw_handshake", 32'(seen), 32'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic rd_beat(input logic [AW-1:0] exp_sa, input logic [31:0] exp_d,
                         input logic exp_last, input logic [3:0] exp_id, input int hold);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (sram_en) begin seen = 1; break; end
    end
    chk("rd_req_seen", 32'(seen), 32'd1);
    chk("rd_sram_addr", 32'(sram_addr), 32'(exp_sa));
    chk("rd_sram_wen", 32'(sram_wen), 32'd0);
    @(negedge aclk);
    chk("rd_wait_rvalid", 32'(rvalid), 32'd0);
    @(negedge aclk);
    chk("rvalid", 32'(rvalid), 32'd1);
    chk("rdata", rdata, exp_d);
    chk("rid", 32'(rid), 32'(exp_id));
    chk("rlast", 32'(rlast), 32'(exp_last));
    chk("rresp", 32'(rresp), 32'd0);
    if (hold > 0) begin
      rready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge aclk);
        chk("hold_rvalid", 32'(rvalid), 32'd1);
        chk("hold_rdata", rdata, exp_d);
        chk("hold_sram_en", 32'(sram_en), 32'd0);
      end
      rready = 1'b1;
    end
    @(posedge aclk); #1;
  endtask

  task automatic wr_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                         input logic [AW-1:0] exp_sa);
    bit seen = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (wready) begin seen = 1; break; end
    end
    chk("w_handshake", 32'(seen), 32'd1);
    chk("wr_sram_en", 32'(sram_en), 32'd1);
    chk("wr_sram_wen", 32'(sram_wen), 32'(s));
    chk("wr_sram_addr", 32'(sram_addr), 32'(exp_sa));
    chk("wr_sram_wdata", sram_wdata, d);
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_b(input logic [3:0] exp_id, input logic [1:0] exp_resp);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (bvalid) begin seen = 1; break; end
    end
    chk("bvalid_seen", 32'(seen), 32'd1);
    chk("bid", 32'(bid), 32'(exp_id));
    chk("bresp", 32'(bresp), 32'(exp_resp));
    @(posedge aclk); #1;
  endtask

  typedef struct {
    bit            is_wr;
    logic [3:0]    id;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [AW-1:0] exp_sa;
    logic [31:0]   exp_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 4'd3,  32'h0000_0100, 32'h0,          4'h0, 16'h0040, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 4'd5,  32'h0000_0104, 32'h0000_00AA,  4'h1, 16'h0041, 32'h0};
    vecs[2] = '{1'b0, 4'd6,  32'h0000_0104, 32'h0,          4'h0, 16'h0041, 32'h123456AA};
    vecs[3] = '{1'b1, 4'd9,  32'h0000_0108, 32'hCAFE_F00D,  4'hC, 16'h0042, 32'h0};
    vecs[4] = '{1'b0, 4'hF,  32'h0000_0108, 32'h0,          4'h0, 16'h0042, 32'hCAFE1111};
    vecs[5] = '{1'b0, 4'd1,  32'h0004_0010, 32'h0,          4'h0, 16'h0004, 32'h0BADF00D};
    vecs[6] = '{1'b1, 4'd2,  32'hFFFF_FFFC, 32'h5566_7788,  4'hF, 16'hFFFF, 32'h0};
    vecs[7] = '{1'b0, 4'd0,  32'hFFFF_FFFC, 32'h0,          4'h0, 16'hFFFF, 32'h55667788};

    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b1;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b1;
    rready = 1'b1; bready = 1'b1;

    // Reset state with valids asserted
    repeat (3) @(negedge aclk);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    chk("rst_sram_wen", 32'(sram_wen), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // First tie after reset: read wins, write follows
    start_ar(4'd3, 32'h100, 8'd0, 2'b01);
    start_aw(4'd7, 32'h10C, 4'd0, 2'b01);
    @(negedge aclk);
    chk("tie1_arready", 32'(arready), 32'd1);
    chk("tie1_awready", 32'(awready), 32'd0);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    rd_beat(16'h0040, 32'hDEADBEEF, 1'b1, 4'd3, 0);
    finish_aw();
    wr_beat(32'h01020304, 4'hF, 1'b1, 16'h0043);
    wait_b(4'd7, 2'b00);

    // Single-beat table
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].is_wr) begin
        start_aw(vecs[v].id, vecs[v].addr, 4'd0, 2'b01);
        finish_aw();
        wr_beat(vecs[v].wdata, vecs[v].wstrb, 1'b1, vecs[v].exp_sa);
        wait_b(vecs[v].id, 2'b00);
      end else begin
        start_ar(vecs[v].id, vecs[v].addr, 8'd0, 2'b01);
        finish_ar();
        rd_beat(vecs[v].exp_sa, vecs[v].exp_rdata, 1'b1, vecs[v].id, 0);
      end
    end

    // Second tie: write wins this time
    start_ar(4'd4, 32'h10C, 8'd0, 2'b01);
    start_aw(4'd8, 32'h110, 4'd0, 2'b01);
    @(negedge aclk);
    chk("tie2_awready", 32'(awready), 32'd1);
    chk("tie2_arready", 32'(arready), 32'd0);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    wr_beat(32'h0A0B0C0D, 4'hF, 1'b1, 16'h0044);
    wait_b(4'd8, 2'b00);
    finish_ar();
    rd_beat(16'h0043, 32'h01020304, 1'b1, 4'd4, 0);

    // 4-beat INCR read, beat 1 throttled for 5 cycles
    start_ar(4'd2, 32'h200, 8'd3, 2'b01);
    finish_ar();
    rd_beat(16'h0080, 32'hA0000080, 1'b0, 4'd2, 0);
    rd_beat(16'h0081, 32'hA0000081, 1'b0, 4'd2, 5);
    rd_beat(16'h0082, 32'hA0000082, 1'b0, 4'd2, 0);
    rd_beat(16'h0083, 32'hA0000083, 1'b1, 4'd2, 0);

    // FIXED burst keeps the address; upper arlen bits ignored
    start_ar(4'd1, 32'h100, 8'hF1, 2'b00);
    finish_ar();
    rd_beat(16'h0040, 32'hDEADBEEF, 1'b0, 4'd1, 0);
    rd_beat(16'h0040, 32'hDEADBEEF, 1'b1, 4'd1, 0);

    // wlast early on a 2-beat write: both beats written, SLVERR
    start_aw(4'hA, 32'h300, 4'd1, 2'b01);
    finish_aw();
    @(negedge aclk);
    chk("wdata_idle_wready", 32'(wready), 32'd1);
    chk("wdata_idle_sram_en", 32'(sram_en), 32'd0);
    @(posedge aclk); #1;
    wr_beat(32'h11223344, 4'hF, 1'b1, 16'h00C0);
    wr_beat(32'h55667788, 4'h3, 1'b1, 16'h00C1);
    wait_b(4'hA, 2'b10);
    start_aw(4'hB, 32'h304, 4'd0, 2'b01);
    finish_aw();
    wr_beat(32'h99AABBCC, 4'hF, 1'b1, 16'h00C1);
    wait_b(4'hB, 2'b00);
    start_ar(4'd7, 32'h300, 8'd1, 2'b01);
    finish_ar();
    rd_beat(16'h00C0, 32'h11223344, 1'b0, 4'd7, 0);
    rd_beat(16'h00C1, 32'h99AABBCC, 1'b1, 4'd7, 0);

    // Reset during RD_RESP of an 8-beat read
    begin : mid_reset
      bit seen = 0;
      rready = 1'b0;
      start_ar(4'd6, 32'h200, 8'd7, 2'b01);
      finish_ar();
      for (int i = 0; i < 20; i++) begin
        @(negedge aclk);
        if (rvalid) begin seen = 1; break; end
      end
      chk("mid_rvalid_seen", 32'(seen), 32'd1);
      #1 aresetn = 1'b0;
      #1;
      chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
      chk("mid_rst_rid", 32'(rid), 32'd0);
      for (int i = 0; i < 2; i++) begin
        @(negedge aclk);
        chk("mid_rst_sram_en", 32'(sram_en), 32'd0);
      end
      aresetn = 1'b1;
      rready = 1'b1;
      @(negedge aclk);
      chk("post_rst_sram_en", 32'(sram_en), 32'd0);
      chk("post_rst_rvalid", 32'(rvalid), 32'd0);
      start_ar(4'd5, 32'h100, 8'd0, 2'b01);
      #1;
      chk("post_rst_arready", 32'(arready), 32'd1);
      @(posedge aclk); #1;
      arvalid = 1'b0;
      rd_beat(16'h0040, 32'hDEADBEEF, 1'b1, 4'd5, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
